jt49_dcrestore: RTL and testbench



---
 rtl/jt49_dcrestore.sv | 136 +++++++++++++
 tb/tb_jt49_dcrestore.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jt49_dcrestore.sv
// jt49_dcrestore: re-inserts the mid-scale DC offset ahead of the DAC, with click-free ramps on unmute/mute.
// Optional peak-hold magnitude meter on port peak when JT49_DCRST_PEAK_EN is defined.
module jt49_dcrestore #(
    parameter int DW     = 8,
    parameter int STEPW  = 4,
    parameter int DECAYW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          mute,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          ready
`ifdef JT49_DCRST_PEAK_EN
    ,
    output logic [DW-2:0] peak
`endif
);

    localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_OFF,
        ST_UP,
        ST_RUN,
        ST_DOWN
    } state_t;

    state_t             state, state_nxt;
    logic [DW-1:0]      off, off_nxt;
    logic [STEPW-1:0]   pcnt;
    logic [DW-1:0]      dout_nxt;
    logic [DW:0]        run_sum;
    logic               step;

    if (DW < 2 || STEPW < 1 || DECAYW < 1) begin : g_bad_cfg
        $error("jt49_dcrestore: invalid parameter set");
    end

    assign step = &pcnt;

    // State register: everything advances only on cen
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OFF;
            off   <= '0;
            pcnt  <= '0;
            dout  <= '0;
        end else if (cen) begin
            state <= state_nxt;
            off   <= off_nxt;
            pcnt  <= pcnt + STEPW'(1);
            dout  <= dout_nxt;
        end
    end

    // Next-state: a mute change reverses the ramp in place, keeping off
    always_comb begin
        state_nxt = state;
        off_nxt   = off;
        case (state)
            ST_OFF: begin
                if (!mute) state_nxt = ST_UP;
            end
            ST_UP: begin
                if (mute) begin
                    state_nxt = ST_DOWN;
                end else if (step) begin
                    off_nxt = off + DW'(1);
                    if (off_nxt == MID) state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mute) begin
                    state_nxt = ST_DOWN;
                    off_nxt   = MID;
                end
            end
            ST_DOWN: begin
                if (!mute) begin
                    state_nxt = ST_UP;
                end else if (step) begin
                    if (off != '0) off_nxt = off - DW'(1);
                    if (off <= DW'(1)) state_nxt = ST_OFF;
                end
            end
            default: begin
                state_nxt = ST_OFF;
                off_nxt   = '0;
            end
        endcase
    end

    // Outputs: signal path only in RUN, otherwise the ramp offset
    always_comb begin
        run_sum  = {din[DW-1], din} + {1'b0, MID};
        dout_nxt = off;
        case (state)
            ST_OFF:  dout_nxt = '0;
            ST_RUN:  dout_nxt = run_sum[DW-1:0];
            default: dout_nxt = off;
        endcase
    end

    assign ready = (state == ST_RUN);

`ifdef JT49_DCRST_PEAK_EN
    logic [DECAYW-1:0] dcnt;
    logic [DW-2:0]     mag;

    // Low DW-1 bits of -din; -MID leaves them zero and saturates to MID-1
    always_comb begin
        mag = din[DW-2:0];
        if (din[DW-1]) begin
            mag = (~din[DW-2:0]) + (DW-1)'(1);
            if (din[DW-2:0] == '0) mag = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak <= '0;
            dcnt <= '0;
        end else if (cen) begin
            dcnt <= dcnt + DECAYW'(1);
            if (state == ST_RUN && mag > peak) begin
                peak <= mag;
            end else if (&dcnt && peak != '0) begin
                peak <= peak - (DW-1)'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_jt49_dcrestore.sv
// Self-checking bench for jt49_dcrestore: directed ramps, RUN sweep, mute reversal, sparse cen, reset.
// Peak-meter checks compile in only with JT49_DCRST_PEAK_EN.
module tb_jt49_dcrestore;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       mute = 1'b1;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       ready;
`ifdef JT49_DCRST_PEAK_EN
    logic [6:0] peak;
`endif

    int compared = 0;
    int mismatched = 0;

    jt49_dcrestore #(.DW(8), .STEPW(4), .DECAYW(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen),
        .mute  (mute),
        .din   (din),
        .dout  (dout),
        .ready (ready)
`ifdef JT49_DCRST_PEAK_EN
        ,
        .peak  (peak)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: 0=off 1=up 2=run 3=down; ramp steps on every 16th cen since reset
    int m_mode, m_off, m_cen_count;
    int exp_dout, exp_ready;
    int emit_kind;          // 0 = ramp/off value, 1 = live signal, 2 = reset
    bit m_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_off = 0; m_cen_count = 0;
            exp_dout = 0; exp_ready = 0; emit_kind = 2; m_valid = 1;
        end else if (cen) begin
            bit stepped;
            stepped = (m_cen_count % 16) == 15;
            m_cen_count++;
            if (m_mode == 2) begin
                exp_dout  = (int'($signed(din)) + 128) & 255;
                emit_kind = 1;
            end else begin
                exp_dout  = (m_mode == 0) ? 0 : m_off;
                emit_kind = 0;
            end
            if (m_mode == 0) begin
                if (!mute) m_mode = 1;
            end else if (m_mode == 1) begin
                if (mute) m_mode = 3;
                else if (stepped) begin
                    m_off++;
                    if (m_off == 128) m_mode = 2;
                end
            end else if (m_mode == 2) begin
                if (mute) begin m_mode = 3; m_off = 128; end
            end else begin
                if (!mute) m_mode = 1;
                else if (stepped) begin
                    if (m_off > 0) m_off--;
                    if (m_off == 0) m_mode = 0;
                end
            end
            exp_ready = (m_mode == 2) ? 1 : 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, plus the 1-LSB slew rule outside RUN
    int prev_dout = 0;
    int prev_kind = 2;
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model dout", int'(dout), exp_dout);
            chk("model ready", int'(ready), exp_ready);
            if (emit_kind == 0 && prev_kind != 1) begin
                compared++;
                assert ((int'(dout) - prev_dout) <= 1 && (prev_dout - int'(dout)) <= 1)
                else begin
                    mismatched++;
                    $display("FAIL slew: got %0d after %0d, required delta <= 1 at %0t",
                             dout, prev_dout, $time);
                end
            end
            prev_dout = int'(dout);
            prev_kind = emit_kind;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dout(input int target, input int limit, output bit found);
        found = 0;
        for (int i = 0; i < limit && !found; i++) begin
            step();
            if (int'(dout) == target) found = 1;
        end
    endtask

    initial begin
        logic [7:0] sweep_in  [4];
        int         sweep_out [4];
        bit         found;
        int         first;

        sweep_in  = '{8'h80, 8'hFF, 8'h00, 8'h7F};
        sweep_out = '{0, 127, 128, 255};

        repeat (2) step();
        chk("reset dout", int'(dout), 0);
        chk("reset ready", int'(ready), 0);

        // Power-on ramp: one step per 16 cen, RUN on the 2048th cen
        rst = 0; mute = 0; cen = 1;
        for (int i = 1; i <= 2048; i++) begin
            step();
            if (i == 1)    chk("off->up dout", int'(dout), 0);
            if (i == 17)   chk("ramp first step", int'(dout), 1);
            if (i == 33)   chk("ramp second step", int'(dout), 2);
            if (i == 2047) chk("ready before top", int'(ready), 0);
            if (i == 2048) begin
                chk("ready at top", int'(ready), 1);
                chk("dout at top", int'(dout), 127);
            end
        end

        for (int k = 0; k < 4; k++) begin
            din = sweep_in[k];
            step();
            chk("run sweep dout", int'(dout), sweep_out[k]);
            chk("run sweep ready", int'(ready), 1);
        end

`ifdef JT49_DCRST_PEAK_EN
        din = 8'd50; step();
        din = 8'h9C; step();
        chk("peak load 100", int'(peak), 100);
        din = 8'h00;
        repeat (64) step();
        chk("peak decay 99", int'(peak), 99);
        repeat (64) step();
        chk("peak decay 98", int'(peak), 98);
        din = 8'h80; step();
        chk("peak sat 127", int'(peak), 127);
`endif

        // Mute from RUN: ramp down to OFF
        din = 8'h00; mute = 1;
        step();
        chk("mute first dout", int'(dout), 128);
        chk("mute ready", int'(ready), 0);
        repeat (2100) step();
        chk("muted dout", int'(dout), 0);
        chk("muted ready", int'(ready), 0);

        // Reversals mid-ramp
        mute = 0;
        wait_dout(40, 1000, found);
        chk("reach 40", int'(found), 1);
        mute = 1;
        wait_dout(20, 1000, found);
        chk("fall to 20", int'(found), 1);
        mute = 0;
        wait_dout(25, 1000, found);
        chk("rise to 25", int'(found), 1);

        // Sparse cen: 2048th cen lands on cycle 3*2047
        rst = 1; step();
        rst = 0; mute = 0;
        first = -1;
        for (int c = 0; c < 6300 && first < 0; c++) begin
            cen = (c % 3 == 0);
            step();
            if (ready) first = c;
        end
        chk("1in3 ramp length", first, 6141);

        cen = 1; din = 8'd50;
        step();
        chk("run after sparse", int'(dout), 178);
        rst = 1;
        step();
        chk("midrun reset dout", int'(dout), 0);
        chk("midrun reset ready", int'(ready), 0);
        rst = 0; mute = 1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
